// File: rtl/rom_prog_pkg.sv
// rom_prog_pkg: shared definitions for the ROM programming sequencer.
//   state_t        - sequencer states (VERIFY is used only when the
//                    ROM_PROG_VERIFY_EN macro is defined)
//   BYTES_PER_WORD - bytes written per instruction word
//   DEFAULT_AW     - default ROM byte-address width
package rom_prog_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPEN   = 3'd1,
        ACCEPT = 3'd2,
        SEND   = 3'd3,
        GAP    = 3'd4,
        VERIFY = 3'd5,
        CLOSE  = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_AW     = 8;

endpackage

// File: rtl/rom_prog_ctrl_if.sv
// rom_prog_ctrl_if: host-to-sequencer instruction word stream.
//   wr_valid - host word valid
//   wr_ready - sequencer can accept a word
//   wr_data  - 32-bit instruction word
//   wr_last  - final word of the session
// Handshake: a word transfers on a clk edge where wr_valid and wr_ready
// are both high. wr_ready does not depend on wr_valid; the host keeps
// wr_data/wr_last stable while wr_valid is high and not yet accepted.
interface rom_prog_ctrl_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);

endinterface

// File: rtl/rom_word_splitter.sv
// rom_word_splitter: holds the accepted instruction word and selects the
// byte currently being written (little-endian: sel=0 is bits 7:0).
//   clk, rst - clock, synchronous active-low reset
//   load     - capture din into the word register
//   din      - incoming instruction word
//   sel      - byte index
//   code     - selected byte
//   word     - latched word (only with ROM_PROG_VERIFY_EN, for read-back compare)
module rom_word_splitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] din,
    input  logic [1:0]  sel,
`ifdef ROM_PROG_VERIFY_EN
    output logic [31:0] word,
`endif
    output logic [7:0]  code
);

    logic [31:0] word_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_r <= '0;
        end else if (load) begin
            word_r <= din;
        end
    end

    always_comb begin
        code = word_r[7:0];
        case (sel)
            2'd1:    code = word_r[15:8];
            2'd2:    code = word_r[23:16];
            2'd3:    code = word_r[31:24];
            default: code = word_r[7:0];
        endcase
    end

`ifdef ROM_PROG_VERIFY_EN
    assign word = word_r;
`endif

endmodule

// File: rtl/rom_prog_ctrl.sv
// rom_prog_ctrl: programming sequencer for the byte-programmed instruction
// ROM. Accepts 32-bit words over a valid/ready stream and writes each as
// four bytes through the ROM edit/unit/code/send port. While idle the CPU
// fetch address is forwarded to the ROM read port; during a session the
// CPU is stalled.
//   clk, rst        - clock, synchronous active-low reset
//   start           - opens a session (ignored unless idle)
//   wr              - word stream (slave side of rom_prog_ctrl_if)
//   cpu_addr        - CPU fetch address
//   rom_address     - ROM read address
//   rom_edit/unit/code/send - ROM programming port
//   cpu_stall, busy - high while a session runs
//   done            - one-cycle pulse at session end
//   overflow        - sticky: word arrived after capacity was exhausted
//   error           - sticky: read-back mismatch (verify build only)
//   rom_opcode      - ROM read data (verify build only)
//   dbg_state       - current sequencer state
// Optional feature macro: ROM_PROG_VERIFY_EN adds a two-cycle read-back of
// every written word; when undefined error is tied low.
module rom_prog_ctrl
    import rom_prog_pkg::*;
#(
    parameter int AW        = DEFAULT_AW,
    parameter int BASE_ADDR = 0,
    parameter int SEND_GAP  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    rom_prog_ctrl_if.slave wr,
    input  logic [AW-1:0]  cpu_addr,
    output logic [AW-1:0]  rom_address,
    output logic           rom_edit,
    output logic [AW-1:0]  rom_unit,
    output logic [7:0]     rom_code,
    output logic           rom_send,
    output logic           cpu_stall,
    output logic           busy,
    output logic           done,
    output logic           overflow,
    output logic           error,
`ifdef ROM_PROG_VERIFY_EN
    input  logic [31:0]    rom_opcode,
`endif
    output state_t         dbg_state
);

    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [3:0]    GAP_LAST = 4'(SEND_GAP - 1);
    localparam logic [1:0]    K_LAST   = 2'(BYTES_PER_WORD - 1);

    state_t        state;
    state_t        after_word;
    state_t        after_byte;
    logic [AW-1:0] ptr;
    logic          wrapped;
    logic          last_q;
    logic [1:0]    k;
    logic [3:0]    gap_cnt;
    logic          hs;
    logic          full;
    logic          load;
    logic [7:0]    byte_code;

`ifdef ROM_PROG_VERIFY_EN
    logic [31:0]   word_q;
    logic [AW-1:0] vaddr;
    logic          vphase;
`endif

    assign wr.wr_ready = (state == ACCEPT);
    assign hs          = wr.wr_valid & wr.wr_ready;
    // Capacity is exhausted once the pointer has wrapped back to zero.
    assign full        = wrapped & (ptr == '0);
    assign load        = hs & ~full;

    rom_word_splitter u_split (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (wr.wr_data),
        .sel  (k),
`ifdef ROM_PROG_VERIFY_EN
        .word (word_q),
`endif
        .code (byte_code)
    );

    always_comb begin
        after_word = last_q ? CLOSE : ACCEPT;
        if (k != K_LAST) begin
            after_byte = SEND;
        end else begin
`ifdef ROM_PROG_VERIFY_EN
            after_byte = VERIFY;
`else
            after_byte = after_word;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= BASE;
            wrapped  <= 1'b0;
            last_q   <= 1'b0;
            k        <= 2'd0;
            gap_cnt  <= 4'd0;
            done     <= 1'b0;
            overflow <= 1'b0;
            error    <= 1'b0;
`ifdef ROM_PROG_VERIFY_EN
            vaddr    <= '0;
            vphase   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= OPEN;
                        ptr      <= BASE;
                        wrapped  <= 1'b0;
                        overflow <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                OPEN: state <= ACCEPT;
                ACCEPT: begin
                    if (hs) begin
                        if (full) begin
                            // Word is consumed but dropped; session ends.
                            overflow <= 1'b1;
                            state    <= CLOSE;
                        end else begin
                            last_q <= wr.wr_last;
                            k      <= 2'd0;
                            state  <= SEND;
`ifdef ROM_PROG_VERIFY_EN
                            vaddr  <= ptr;
`endif
                        end
                    end
                end
                SEND: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == '1) begin
                        wrapped <= 1'b1;
                    end
                    if (SEND_GAP == 0) begin
                        if (k != K_LAST) begin
                            k <= k + 2'd1;
                        end
                        state <= after_byte;
`ifdef ROM_PROG_VERIFY_EN
                        vphase <= 1'b0;
`endif
                    end else begin
                        gap_cnt <= 4'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (k != K_LAST) begin
                            k <= k + 2'd1;
                        end
                        state <= after_byte;
`ifdef ROM_PROG_VERIFY_EN
                        vphase <= 1'b0;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
`ifdef ROM_PROG_VERIFY_EN
                VERIFY: begin
                    // First cycle presents the address, second samples data.
                    if (!vphase) begin
                        vphase <= 1'b1;
                    end else begin
                        if (rom_opcode != word_q) begin
                            error <= 1'b1;
                        end
                        state <= after_word;
                    end
                end
`endif
                CLOSE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROM_PROG_VERIFY_EN
    assign rom_address = (state == VERIFY) ? vaddr : cpu_addr;
`else
    assign rom_address = cpu_addr;
`endif

    assign rom_edit  = (state == OPEN) || (state == ACCEPT) ||
                       (state == SEND) || (state == GAP);
    assign rom_send  = (state == SEND);
    assign rom_unit  = rom_send ? ptr : '0;
    assign rom_code  = rom_send ? byte_code : 8'h00;
    assign busy      = (state != IDLE);
    assign cpu_stall = busy;
    assign dbg_state = state;

endmodule

// File: tb/tb_rom_prog_ctrl.sv
// tb_rom_prog_ctrl: bench for rom_prog_ctrl. Two instances share clock and
// reset: dut 0 with BASE_ADDR=4, dut 1 with BASE_ADDR=0, both SEND_GAP=1.
// Build with ROM_PROG_VERIFY_EN defined to exercise read-back; the ROM
// model then corrupts byte 05 of dut 0.
`timescale 1ns/1ps
module tb_rom_prog_ctrl;
    import rom_prog_pkg::*;

    localparam int AW   = 8;
    localparam int GAPN = 1;
    localparam int W    = 18;  // {dut, first_of_word, unit[7:0], code[7:0]}
`ifdef ROM_PROG_VERIFY_EN
    localparam logic VE = 1'b1;
`else
    localparam logic VE = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] cpu_addr;
    logic          start [2];
    logic          valid [2];
    logic          last  [2];
    logic [31:0]   data  [2];
    logic          ready [2];
    logic          edit  [2];
    logic          send  [2];
    logic          stall [2];
    logic          busy  [2];
    logic          done  [2];
    logic          ovf   [2];
    logic          err   [2];
    logic [AW-1:0] raddr [2];
    logic [AW-1:0] unit  [2];
    logic [7:0]    code  [2];
    state_t        dbg   [2];
`ifdef ROM_PROG_VERIFY_EN
    logic [7:0]    rom_mem [2][256];
`endif

    for (genvar i = 0; i < 2; i++) begin : g
        rom_prog_ctrl_if wif ();
        assign wif.wr_valid = valid[i];
        assign wif.wr_data  = data[i];
        assign wif.wr_last  = last[i];
        assign ready[i]     = wif.wr_ready;
`ifdef ROM_PROG_VERIFY_EN
        logic [31:0] opcode;
        assign opcode = {rom_mem[i][raddr[i] + 8'd3], rom_mem[i][raddr[i] + 8'd2],
                         rom_mem[i][raddr[i] + 8'd1], rom_mem[i][raddr[i]]};
`endif
        rom_prog_ctrl #(.AW(AW), .BASE_ADDR(i == 0 ? 4 : 0), .SEND_GAP(GAPN)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[i]),
            .wr          (wif.slave),
            .cpu_addr    (cpu_addr),
            .rom_address (raddr[i]),
            .rom_edit    (edit[i]),
            .rom_unit    (unit[i]),
            .rom_code    (code[i]),
            .rom_send    (send[i]),
            .cpu_stall   (stall[i]),
            .busy        (busy[i]),
            .done        (done[i]),
            .overflow    (ovf[i]),
            .error       (err[i]),
`ifdef ROM_PROG_VERIFY_EN
            .rom_opcode  (opcode),
`endif
            .dbg_state   (dbg[i])
        );
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int written  [2];
    int exp_dones[2];
    int dones    [2];
    int sends    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int base_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    // Reference model: a session writes consecutive bytes from its base
    // address until 2**AW - base bytes are used; a word past that is dropped
    // and closes the session.
    task automatic model_word(input int d, input logic [31:0] w, input logic l,
                              output logic closes);
        int cap;
        logic [7:0] a;
        logic [7:0] b;
        cap = (1 << AW) - base_of(d);
        if (written[d] >= cap) begin
            closes = 1'b1;
        end else begin
            for (int kk = 0; kk < 4; kk++) begin
                a = 8'((base_of(d) + written[d] + kk) % (1 << AW));
                b = 8'(w >> (8 * kk));
                exp_q.push_back({1'(d), (kk == 0), a, b});
            end
            written[d] += 4;
            closes = l;
        end
        if (closes) exp_dones[d]++;
    endtask

    // monitor
    int cyc = 0;
    int last_send_cyc[2];
    logic prev_edit[2];
    logic [W-1:0] mon_e;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (send[d]) begin
                sends[d]++;
`ifdef ROM_PROG_VERIFY_EN
                rom_mem[d][unit[d]] = (d == 0 && unit[d] == 8'h05) ? (code[d] ^ 8'h01) : code[d];
`endif
                check("edit_during_send", 32'(edit[d]), 32'd1);
                check("edit_before_send", 32'(prev_edit[d]), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_send: dut%0d unit %0h code %0h, expected no send", d, unit[d], code[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("send_dut", 32'(d), 32'(mon_e[17]));
                    check("send_unit", 32'(unit[d]), 32'(mon_e[15:8]));
                    check("send_code", 32'(code[d]), 32'(mon_e[7:0]));
                    if (!mon_e[16]) check("send_spacing", 32'(cyc - last_send_cyc[d]), 32'(1 + GAPN));
                end
                last_send_cyc[d] = cyc;
            end
            if (done[d]) dones[d]++;
            prev_edit[d] = edit[d];
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        written[d] = 0;
        check("stall_in_session", 32'(stall[d]), 32'd1);
        check("edit_in_open", 32'(edit[d]), 32'd1);
        check("ready_in_open", 32'(ready[d]), 32'd0);
        check("err_cleared", 32'(err[d]), 32'd0);
    endtask

    task automatic put_word(input int d, input logic [31:0] w, input logic l);
        int budget;
        logic ok;
        logic closes;
        valid[d] = 1'b1;
        data[d]  = w;
        last[d]  = l;
        budget   = 40;
        ok       = 1'b0;
        while (budget > 0 && !ok) begin
            @(negedge clk);
            if (ready[d]) ok = 1'b1;
            else budget--;
        end
        check("handshake_in_time", 32'(ok), 32'd1);
        tick();
        valid[d] = 1'b0;
        last[d]  = 1'b0;
        model_word(d, w, l, closes);
    endtask

    task automatic wait_done(input int d);
        int budget;
        logic seen;
        budget = 60;
        seen   = 1'b0;
        while (budget > 0 && !seen) begin
            @(negedge clk);
            if (done[d]) seen = 1'b1;
            else budget--;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("stall_at_done", 32'(stall[d]), 32'd0);
            check("busy_at_done", 32'(busy[d]), 32'd0);
            @(negedge clk);
            check("done_one_cycle", 32'(done[d]), 32'd0);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int s0;
        int s1;
        int n;
        int d;
        int budget;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; valid[i] = 1'b0; last[i] = 1'b0; data[i] = '0;
            written[i] = 0; exp_dones[i] = 0; dones[i] = 0; sends[i] = 0;
            last_send_cyc[i] = 0; prev_edit[i] = 1'b0;
        end
        cpu_addr = 8'h20;

        // reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_state", 32'(dbg[i]), 32'(IDLE));
            check("rst_edit", 32'(edit[i]), 32'd0);
            check("rst_send", 32'(send[i]), 32'd0);
            check("rst_unit", 32'(unit[i]), 32'd0);
            check("rst_code", 32'(code[i]), 32'd0);
            check("rst_ready", 32'(ready[i]), 32'd0);
            check("rst_stall", 32'(stall[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_ovf", 32'(ovf[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
            check("rst_romaddr", 32'(raddr[i]), 32'h20);
        end
        cpu_addr = 8'h37;
        #1;
        check("romaddr_follows", 32'(raddr[0]), 32'h37);
        cpu_addr = 8'h20;
        tick();

        // single word at base 4
        do_start(0);
        put_word(0, 32'h021F00FF, 1'b1);
        wait_done(0);
        check("single_err", 32'(err[0]), 32'(VE));
        check("single_ovf", 32'(ovf[0]), 32'd0);

        // back-pressure in ACCEPT
        do_start(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_edit", 32'(edit[0]), 32'd1);
            check("bp_ready", 32'(ready[0]), 32'd1);
            check("bp_send", 32'(send[0]), 32'd0);
        end
        tick();
        for (int i = 0; i < 3; i++) put_word(0, $urandom, i == 2);
        wait_done(0);

        // random sessions on either instance
        for (int s = 0; s < 5; s++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 4);
            do_start(d);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                put_word(d, $urandom, i == n - 1);
            end
            wait_done(d);
            check("rand_err", 32'(err[d]), (d == 0) ? 32'(VE) : 32'd0);
            check("rand_ovf", 32'(ovf[d]), 32'd0);
        end

        // overflow at base 0: 64 words fill the ROM, the 65th is dropped
        do_start(1);
        s0 = sends[1];
        for (int i = 0; i < 65; i++) begin
            put_word(1, $urandom, 1'b0);
            if (i == 63) check("ovf_before_full", 32'(ovf[1]), 32'd0);
            if (i == 64) check("ovf_on_65th", 32'(ovf[1]), 32'd1);
        end
        wait_done(1);
        check("ovf_sticky", 32'(ovf[1]), 32'd1);
        check("ovf_send_count", 32'(sends[1] - s0), 32'd256);
        do_start(1);
        check("ovf_cleared", 32'(ovf[1]), 32'd0);
        put_word(1, 32'hA5C3_0F96, 1'b1);
        wait_done(1);

        // leave dut 1 with a flag set so reset clearing is visible
        do_start(1);
        for (int i = 0; i < 65; i++) put_word(1, $urandom, 1'b0);
        wait_done(1);

        // reset during the gap after the second byte
        do_start(0);
        s0 = sends[0];
        put_word(0, 32'h1122_3344, 1'b1);
        budget = 30;
        while (budget > 0 && sends[0] < s0 + 2) begin
            tick();
            budget--;
        end
        check("second_send_seen", 32'(sends[0] - s0), 32'd2);
        rst = 1'b0;
        tick();
        check("midrst_edit", 32'(edit[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_state", 32'(dbg[0]), 32'(IDLE));
        check("midrst_ovf_clr", 32'(ovf[1]), 32'd0);
        exp_q.delete();
        exp_dones[0]--;
        s1 = sends[0];
        repeat (4) tick();
        rst = 1'b1;
        repeat (12) tick();
        check("no_send_after_rst", 32'(sends[0]), 32'(s1));

        for (int i = 0; i < 2; i++) check("done_count", 32'(dones[i]), 32'(exp_dones[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
